// File: rtl/regmask_encoder.sv
// regmask_encoder
// ---------------
// Turns a 32-bit register-select mask into a stream of 5-bit register
// indices, one per accepted handshake. It is the inverse of a write-select
// decoder: the indices it emits, decoded back to one-hot and OR-ed together,
// rebuild the captured mask.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// the producer's valid and the consumer's ready are both 1. A valid producer
// holds its payload stable until that transfer takes place.
//
// Parameter
//   LOW_FIRST    1 = lowest set bit first, 0 = highest set bit first
//
// Ports
//   clock        single clock, rising edge
//   ctrl_reset   asynchronous active-low reset
//   load_valid   a new mask is offered on load_mask
//   load_ready   the block accepts a mask this cycle (IDLE only)
//   load_mask    register-select mask, bit n = register n
//   idx_valid    idx holds a valid register index (EMIT only)
//   idx_ready    the consumer takes idx this cycle
//   idx          encoded register number
//   remaining    number of indices not yet emitted (0..32)
//   busy         state is not IDLE
//   done         one-cycle pulse after a mask has been fully drained
//   dbg_state    current FSM state (0 IDLE, 1 EMIT, 2 DONE)
//
// Build option
//   REGMASK_ZERO_SKIP_EN  when defined, bit 0 of load_mask is dropped at
//                         capture so register 0 is never emitted or counted.

module regmask_encoder #(
    parameter int LOW_FIRST = 1
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_mask,
    output logic        idx_valid,
    input  logic        idx_ready,
    output logic [4:0]  idx,
    output logic [5:0]  remaining,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] capture_mask;
    logic [4:0]  enc_idx;
    logic [5:0]  pop_cnt;

`ifdef REGMASK_ZERO_SKIP_EN
    assign capture_mask = {load_mask[31:1], 1'b0};
`else
    assign capture_mask = load_mask;
`endif

    // Priority encoder over pending. Scanning from the far end and letting
    // the last hit win leaves the preferred end's bit in enc_idx. With
    // pending at zero (IDLE, DONE, reset) the result is 0.
    always_comb begin
        enc_idx = '0;
        if (LOW_FIRST != 0) begin
            for (int i = 31; i >= 0; i--) begin
                if (pending_q[i]) enc_idx = 5'(i);
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (pending_q[i]) enc_idx = 5'(i);
            end
        end
    end

    // Popcount of pending; 6 bits so an all-ones mask reads 32.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            pop_cnt = pop_cnt + {5'd0, pending_q[i]};
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        load_ready = 1'b0;
        idx_valid  = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    pending_d = capture_mask;
                    state_d   = (capture_mask != 32'd0) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                idx_valid = 1'b1;
                if (idx_ready) begin
                    pending_d = pending_q & ~(32'd1 << enc_idx);
                    // Last set bit just left: go report completion.
                    if (pop_cnt == 6'd1) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign idx       = enc_idx;
    assign remaining = pop_cnt;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/regmask_encoder.md
REGMASK_ENCODER -- requirements
Module: regmask_encoder

Interface
REQ-001 The block SHALL have one parameter: LOW_FIRST, default 1, scan order (1 = lowest set bit first, 0 = highest set bit first).
REQ-002 The block SHALL have port `clock`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `ctrl_reset`: input, 1 bit, reset; asynchronous and active-low.
REQ-004 The block SHALL have port `load_valid`: input, 1 bit, a new 32-bit register mask is offered.
REQ-005 The block SHALL have port `load_ready`: output, 1 bit, the block accepts a mask this cycle.
REQ-006 The block SHALL have port `load_mask`: input, 32 bits, the register-select mask; bit n = register n.
REQ-007 The block SHALL have port `idx_valid`: output, 1 bit, `idx` holds a valid register index.
REQ-008 The block SHALL have port `idx_ready`: input, 1 bit, the consumer takes `idx` this cycle.
REQ-009 The block SHALL have port `idx`: output, 5 bits, the encoded register number.
REQ-010 The block SHALL have port `remaining`: output, 6 bits, the popcount of indices not yet emitted (0..32).
REQ-011 The block SHALL have port `busy`: output, 1 bit, high when the state is not IDLE.
REQ-012 The block SHALL have port `done`: output, 1 bit, a one-cycle pulse when a mask is fully drained.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, EMIT, DONE.
REQ-014 In IDLE, `load_ready` SHALL be 1, `idx_valid` 0, `busy` 0, and `done` 0.
REQ-015 In IDLE with `load_valid`=1, the block SHALL register the mask into `pending` at the clock edge.
REQ-016 On that load, the next state SHALL be EMIT if `pending` is non-zero, else DONE.
REQ-017 `load_ready` SHALL be 0 in EMIT and DONE; `load_valid` in those states SHALL be ignored, with no capture.
REQ-018 In EMIT, `idx_valid` SHALL be 1 and `idx` SHALL be the priority-encoded set bit of `pending` per LOW_FIRST.
REQ-019 The first valid `idx` SHALL appear the cycle after load acceptance (1-cycle latency).
REQ-020 `idx` SHALL remain stable while `idx_valid`=1 and `idx_ready`=0.
REQ-021 In EMIT, a handshake (`idx_valid` & `idx_ready`) SHALL clear bit `idx` of `pending` and decrement `remaining`.
REQ-022 The block SHALL emit at most one index per cycle.
REQ-023 If the handshake clears the last set bit, the next state SHALL be DONE; otherwise the state SHALL stay EMIT.
REQ-024 In DONE, `done` SHALL be 1 for exactly one cycle, `idx_valid` SHALL be 0, and the next state SHALL be IDLE.
REQ-025 The next load SHALL therefore be possible 1 cycle after DONE.
REQ-026 `remaining` SHALL equal the popcount of `pending` at all times and be 0 in IDLE and DONE.
REQ-027 For an all-ones mask, the block SHALL emit 32 indices and `remaining` SHALL start at 32 (no overflow of the 6-bit field).
REQ-028 Each index SHALL be emitted exactly once, with no repeats and no wrap-around.
REQ-029 The output SHALL be the inverse of the write-select decoder: emitted `idx` values decoded back to one-hot, then OR-ed, SHALL equal the captured mask.

Reset
REQ-030 While `ctrl_reset`=0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-031 During reset: `pending`=0, `idx`=0, `idx_valid`=0, `remaining`=0, `busy`=0, `done`=0, `load_ready`=1.
REQ-032 A reset during EMIT SHALL discard the pending mask, with no `done` pulse.
REQ-033 After reset release, the first load SHALL be accepted on the first rising edge with `load_valid`=1.

Configuration
REQ-034 With macro REGMASK_ZERO_SKIP_EN defined, bit 0 of `load_mask` SHALL be forced to 0 at capture, so register 0 is never emitted and never counted.
REQ-035 With REGMASK_ZERO_SKIP_EN defined, a mask of 32'h00000001 SHALL go IDLE->DONE directly.
REQ-036 Without REGMASK_ZERO_SKIP_EN, bit 0 SHALL be treated like any other bit.

Verification
REQ-037 Scenario: LOW_FIRST=1, load 32'h80000105, `idx_ready`=1 -> `idx` = 0, 2, 8, 31 on consecutive cycles; `remaining` = 4, 3, 2, 1; `done` pulses the cycle after idx 31.
REQ-038 Scenario: LOW_FIRST=0, load 32'h00000106 -> `idx` = 8, 2, 1.
REQ-039 Scenario: load 32'h00000010, `idx_ready` held 0 for 5 cycles -> `idx_valid`=1 with `idx`=4 stable for 5 cycles; then ready -> `done` 1 cycle later.
REQ-040 Scenario: load 32'hFFFFFFFF, `idx_ready`=1 -> 32 indices 0..31; `remaining` starts at 32; `busy` high for 33 cycles.
REQ-041 Scenario: load 32'h00000000 -> no `idx_valid`; `done`=1 the cycle after load; `load_ready`=1 the next cycle.
REQ-042 Scenario: reset mid-EMIT after 2 of 4 indices -> all outputs go to reset values immediately; a new load of 32'h00000001 then emits idx 0 (macro off) or produces no emission with `done` (macro on).
